line_set_monitor: RTL and testbench

//   Clocked bit-timing engine for serial lines, e.g. UART tx/rx.
//   The setter drives an N-bit line high, low or to a given value, and holds it for a programmed number of clocks.
//   The monitor waits for an all-low or all-high level on an N-bit input, or checks the input stays constant for a programmed number of clocks.

---
 rtl/line_set_monitor.sv | 194 +++++++++++++++++++
 tb/tb_line_set_monitor.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_set_monitor.sv
// line_set_monitor: bit-timing engine for serial lines.
//   Setter: drives an N-bit line high, low or to set_val and holds it for set_dur clocks.
//   Monitor: waits for an all-low / all-high line, or checks the line stays constant
//   for mon_dur clocks.
// Optional feature macro: MON_SYNC_EN puts mon_in through a 2-flop synchronizer
// before every compare (2 extra clocks of detection latency).
//
// Handshake: set_start/mon_start are sampled on each rising edge. A setter start is
// taken when the setter is idle or in its final (set_done) cycle. A monitor start is
// taken whenever mon_busy is low. Starts presented at any other time are dropped.
// set_done/mon_done are single-cycle pulses. No backpressure exists.
module line_set_monitor #(
  parameter int   N     = 1,
  parameter int   CNT_W = 16,
  parameter logic IDLE  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_start,
  input  logic [1:0]       set_op,
  input  logic [N-1:0]     set_val,
  input  logic [CNT_W-1:0] set_dur,
  output logic [N-1:0]     set_out,
  output logic             set_busy,
  output logic             set_done,
  input  logic [N-1:0]     mon_in,
  input  logic             mon_start,
  input  logic [1:0]       mon_op,
  input  logic [CNT_W-1:0] mon_dur,
  output logic             mon_busy,
  output logic             mon_done,
  output logic             mon_err,
  output logic [N-1:0]     mon_val,
  output logic             set_state_dbg,
  output logic [1:0]       mon_state_dbg
);

  typedef enum logic {S_IDLE, S_HOLD} set_state_t;
  typedef enum logic [1:0] {M_IDLE, M_WAIT, M_CHECK} mon_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ---------------- setter ----------------
  set_state_t       set_state, set_state_nxt;
  logic [CNT_W-1:0] set_cnt, set_cnt_nxt;
  logic [N-1:0]     set_out_nxt, set_level;
  logic             set_zero_done, set_zero_done_nxt;
  logic             set_accept;

  assign set_busy      = (set_state == S_HOLD);
  assign set_done      = (set_busy && set_cnt == CNT_ONE) || set_zero_done;
  assign set_accept    = set_start && (!set_busy || set_done);
  assign set_state_dbg = set_state;

  // Setter register bank; the line returns to the idle level only on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_state     <= S_IDLE;
      set_cnt       <= '0;
      set_out       <= {N{IDLE}};
      set_zero_done <= 1'b0;
    end else begin
      set_state     <= set_state_nxt;
      set_cnt       <= set_cnt_nxt;
      set_out       <= set_out_nxt;
      set_zero_done <= set_zero_done_nxt;
    end
  end

  // Setter next state: a zero-length hold stays idle and only pulses done once.
  always_comb begin
    set_state_nxt     = set_state;
    set_cnt_nxt       = set_cnt;
    set_out_nxt       = set_out;
    set_zero_done_nxt = 1'b0;
    set_level         = set_val;
    if (set_op == 2'b00)      set_level = '1;
    else if (set_op == 2'b01) set_level = '0;
    if (set_accept) begin
      set_out_nxt = set_level;
      set_cnt_nxt = set_dur;
      if (set_dur == '0) begin
        set_state_nxt     = S_IDLE;
        set_zero_done_nxt = 1'b1;
      end else begin
        set_state_nxt = S_HOLD;
      end
    end else if (set_state == S_HOLD) begin
      set_cnt_nxt = set_cnt - CNT_ONE;
      if (set_cnt == CNT_ONE) set_state_nxt = S_IDLE;
    end
  end

  // ---------------- monitor ----------------
  logic [N-1:0] mon_s;

`ifdef MON_SYNC_EN
  logic [N-1:0] sync1, sync2;

  // Two-flop synchronizer for an asynchronous observed line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= mon_in;
      sync2 <= sync1;
    end
  end
  assign mon_s = sync2;
`else
  assign mon_s = mon_in;
`endif

  mon_state_t       mon_state, mon_state_nxt;
  logic [CNT_W-1:0] mon_cnt, mon_cnt_nxt;
  logic [N-1:0]     mon_ref, mon_ref_nxt, mon_val_nxt;
  logic             mon_want_high, mon_want_high_nxt;
  logic             mon_err_q, mon_err_nxt;
  logic             mon_done_q, mon_done_nxt;
  logic             mon_mismatch, mon_check_last, mon_match;

  assign mon_mismatch   = (mon_s != mon_ref);
  assign mon_check_last = (mon_state == M_CHECK) && (mon_cnt == CNT_ONE);
  assign mon_match      = mon_want_high ? (mon_s == {N{1'b1}}) : (mon_s == '0);
  assign mon_busy       = (mon_state != M_IDLE);
  // Window checks finish in their last busy cycle, so that cycle's compare is folded in live.
  assign mon_done       = mon_done_q | mon_check_last;
  assign mon_err        = mon_err_q | (mon_check_last & mon_mismatch);
  assign mon_state_dbg  = mon_state;

  // Monitor register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon_state     <= M_IDLE;
      mon_cnt       <= '0;
      mon_ref       <= '0;
      mon_val       <= '0;
      mon_want_high <= 1'b0;
      mon_err_q     <= 1'b0;
      mon_done_q    <= 1'b0;
    end else begin
      mon_state     <= mon_state_nxt;
      mon_cnt       <= mon_cnt_nxt;
      mon_ref       <= mon_ref_nxt;
      mon_val       <= mon_val_nxt;
      mon_want_high <= mon_want_high_nxt;
      mon_err_q     <= mon_err_nxt;
      mon_done_q    <= mon_done_nxt;
    end
  end

  // Monitor next state: level waits complete one clock after the match is seen.
  always_comb begin
    mon_state_nxt     = mon_state;
    mon_cnt_nxt       = mon_cnt;
    mon_ref_nxt       = mon_ref;
    mon_val_nxt       = mon_val;
    mon_want_high_nxt = mon_want_high;
    mon_err_nxt       = mon_err_q;
    mon_done_nxt      = 1'b0;
    case (mon_state)
      M_IDLE: begin
        if (mon_start) begin
          mon_err_nxt = 1'b0;
          if (mon_op[1] == 1'b0) begin
            mon_want_high_nxt = mon_op[0];
            mon_state_nxt     = M_WAIT;
          end else begin
            mon_ref_nxt = mon_s;
            mon_val_nxt = mon_s;
            mon_cnt_nxt = mon_dur;
            if (mon_dur == '0) mon_done_nxt  = 1'b1;
            else               mon_state_nxt = M_CHECK;
          end
        end
      end
      M_WAIT: begin
        if (mon_match) begin
          mon_done_nxt  = 1'b1;
          mon_val_nxt   = mon_s;
          mon_state_nxt = M_IDLE;
        end
      end
      M_CHECK: begin
        mon_cnt_nxt = mon_cnt - CNT_ONE;
        if (mon_mismatch) mon_err_nxt = 1'b1;
        if (mon_cnt == CNT_ONE) mon_state_nxt = M_IDLE;
      end
      default: mon_state_nxt = M_IDLE;
    endcase
  end

endmodule

// File: tb/tb_line_set_monitor.sv
// Testbench for line_set_monitor: directed scenarios plus concurrent random
// setter/monitor traffic, checked against a cycle-indexed reference model.
module tb_line_set_monitor;
  localparam int N        = 2;
  localparam int CNT_W    = 8;
  localparam int PLAN_LEN = 6000;
`ifdef MON_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             set_start = 1'b0;
  logic [1:0]       set_op = 2'b00;
  logic [N-1:0]     set_val = '0;
  logic [CNT_W-1:0] set_dur = '0;
  logic [N-1:0]     set_out;
  logic             set_busy, set_done;
  logic [N-1:0]     mon_in;
  logic             mon_start = 1'b0;
  logic [1:0]       mon_op = 2'b00;
  logic [CNT_W-1:0] mon_dur = '0;
  logic             mon_busy, mon_done, mon_err;
  logic [N-1:0]     mon_val;
  logic             set_state_dbg;
  logic [1:0]       mon_state_dbg;

  line_set_monitor #(.N(N), .CNT_W(CNT_W), .IDLE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .set_start(set_start), .set_op(set_op), .set_val(set_val), .set_dur(set_dur),
    .set_out(set_out), .set_busy(set_busy), .set_done(set_done),
    .mon_in(mon_in), .mon_start(mon_start), .mon_op(mon_op), .mon_dur(mon_dur),
    .mon_busy(mon_busy), .mon_done(mon_done), .mon_err(mon_err), .mon_val(mon_val),
    .set_state_dbg(set_state_dbg), .mon_state_dbg(mon_state_dbg)
  );

  // ---------------- reference model state ----------------
  // plan[c] is the value of mon_in during cycle c (cyc == c).
  logic [N-1:0]   plan [0:PLAN_LEN-1];
  logic [N-1:0]   m_set_lvl = '1;
  int             m_set_lo = 1, m_set_hi = 0;
  int             m_mon_lo = 1, m_mon_hi = 0;
  logic [31+N:0]  set_q [$];   // {done_cycle, level}
  logic [32+N:0]  mon_q [$];   // {done_cycle, err, val}
  bit             checking = 1'b0;
  int             total = 0;
  int             bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Value the monitor compares against during cycle c.
  function automatic logic [N-1:0] seen(input int c);
    if (c - D < 0) return '0;
    return plan[c - D];
  endfunction

  function automatic void model_reset();
    m_set_lvl = '1;
    m_set_lo = 1; m_set_hi = 0;
    m_mon_lo = 1; m_mon_hi = 0;
    set_q.delete();
    mon_q.delete();
  endfunction

  // Line driver: random runs of random levels, applied just after each edge.
  initial begin
    int i;
    i = 0;
    while (i < PLAN_LEN) begin
      logic [N-1:0] v;
      int run;
      v   = N'($urandom_range(0, (1 << N) - 1));
      run = $urandom_range(1, 8);
      for (int k = 0; k < run && i < PLAN_LEN; k++) begin
        plan[i] = v;
        i++;
      end
    end
    mon_in = plan[0];
    forever begin
      @(posedge clk);
      #1;
      mon_in = plan[(cyc < PLAN_LEN) ? cyc : PLAN_LEN - 1];
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (checking) begin
      logic exp_sd, exp_md;
      logic [31+N:0] se;
      logic [32+N:0] me;
      check("set_out", set_out, m_set_lvl);
      check("set_busy", set_busy, (cyc >= m_set_lo && cyc <= m_set_hi));
      check("mon_busy", mon_busy, (cyc >= m_mon_lo && cyc <= m_mon_hi));
      exp_sd = (set_q.size() > 0) && (int'(set_q[0][31+N:N]) == cyc);
      check("set_done", set_done, exp_sd);
      if (exp_sd) begin
        se = set_q.pop_front();
        check("set_done_level", set_out, se[N-1:0]);
      end
      exp_md = (mon_q.size() > 0) && (int'(mon_q[0][32+N:N+1]) == cyc);
      check("mon_done", mon_done, exp_md);
      if (exp_md) begin
        me = mon_q.pop_front();
        check("mon_err", mon_err, me[N]);
        check("mon_val", mon_val, me[N-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cmd(input logic [1:0] op, input logic [N-1:0] val, input int dur);
    int guard, c_e;
    logic [N-1:0] lvl;
    guard = 0;
    @(negedge clk);
    while (set_busy && !set_done) begin
      // Starts offered mid-hold must be dropped.
      set_start = ($urandom_range(0, 3) == 0);
      set_op    = 2'($urandom_range(0, 3));
      set_val   = N'($urandom_range(0, (1 << N) - 1));
      set_dur   = CNT_W'($urandom_range(0, 5));
      guard++;
      if (guard > 2000) begin
        check("set_idle_timeout", 1, 0);
        set_start = 1'b0;
        return;
      end
      @(negedge clk);
    end
    set_start = 1'b1;
    set_op    = op;
    set_val   = val;
    set_dur   = CNT_W'(dur);
    c_e = cyc + 1;
    lvl = (op == 2'b00) ? '1 : (op == 2'b01) ? '0 : val;
    @(posedge clk);
    #1;
    set_start = 1'b0;
    m_set_lvl = lvl;
    m_set_lo  = c_e;
    m_set_hi  = c_e + dur - 1;
    set_q.push_back({32'(c_e + ((dur > 0) ? dur : 1) - 1), lvl});
  endtask

  task automatic mon_cmd(input logic [1:0] op_in, input int dur);
    int guard, c_e, done_c, found;
    logic [1:0] op;
    logic [N-1:0] ref_v, want, val_e;
    logic err_e;
    op = op_in;
    guard = 0;
    @(negedge clk);
    while (mon_busy) begin
      mon_start = ($urandom_range(0, 3) == 0);
      mon_op    = 2'($urandom_range(0, 3));
      mon_dur   = CNT_W'($urandom_range(0, 5));
      guard++;
      if (guard > 2000) begin
        check("mon_idle_timeout", 1, 0);
        mon_start = 1'b0;
        return;
      end
      @(negedge clk);
    end
    c_e = cyc + 1;
    err_e = 1'b0;
    if (op[1] == 1'b0) begin
      want = op[0] ? '1 : '0;
      found = -1;
      for (int c = c_e; c < c_e + 300 && c < PLAN_LEN; c++) begin
        if (seen(c) == want) begin
          found = c;
          break;
        end
      end
      if (found < 0) op = 2'b10;
      else begin
        done_c = found + 1;
        val_e  = want;
      end
    end
    if (op[1] == 1'b1) begin
      ref_v = seen(c_e - 1);
      for (int c = c_e; c < c_e + dur; c++)
        if (seen(c) != ref_v) err_e = 1'b1;
      done_c = c_e + ((dur > 0) ? dur : 1) - 1;
      val_e  = ref_v;
    end
    mon_start = 1'b1;
    mon_op    = op;
    mon_dur   = CNT_W'(dur);
    @(posedge clk);
    #1;
    mon_start = 1'b0;
    m_mon_lo  = c_e;
    m_mon_hi  = (op[1] == 1'b0) ? done_c - 1 : c_e + dur - 1;
    mon_q.push_back({32'(done_c), err_e, val_e});
  endtask

  task automatic wait_all_idle();
    int guard;
    guard = 0;
    while ((set_q.size() > 0 || mon_q.size() > 0) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", (set_q.size() + mon_q.size()), 0);
    @(negedge clk);
  endtask

  task automatic check_reset_values();
    check("rst_set_out", set_out, {N{1'b1}});
    check("rst_set_busy", set_busy, 0);
    check("rst_set_done", set_done, 0);
    check("rst_mon_busy", mon_busy, 0);
    check("rst_mon_done", mon_done, 0);
    check("rst_mon_err", mon_err, 0);
    check("rst_mon_val", mon_val, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cur;
    logic [N-1:0] v;
    logic [9:0] frame;

    #2 rst = 1'b1;
    #1 check_reset_values();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    checking = 1'b1;

    // Low for 10 cycles.
    set_cmd(2'b01, '0, 10);
    wait_all_idle();

    // Asynchronous reset in the middle of a hold.
    set_cmd(2'b01, '0, 20);
    repeat (4) @(negedge clk);
    checking = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checking = 1'b1;

    // 0x55 UART frame, start 0, LSB first, stop 1, chained on set_done.
    frame = {1'b1, 8'h55, 1'b0};
    for (int b = 0; b < 10; b++)
      set_cmd(frame[b] ? 2'b00 : 2'b01, '0, 10);
    wait_all_idle();

    // Value drive and the maximum hold length.
    set_cmd(2'b10, 2'b10, 3);
    set_cmd(2'b11, 2'b01, (1 << CNT_W) - 1);
    wait_all_idle();

    // wait_low: line high, falls later.
    @(negedge clk);
    cur = cyc;
    for (int c = cur + 1; c <= cur + 12; c++) plan[c] = '1;
    for (int c = cur + 13; c <= cur + 40; c++) plan[c] = '0;
    repeat (3) @(negedge clk);
    mon_cmd(2'b00, 0);
    wait_all_idle();

    // wait_high on a line already high.
    @(negedge clk);
    cur = cyc;
    for (int c = cur + 1; c <= cur + 40; c++) plan[c] = '1;
    repeat (3) @(negedge clk);
    mon_cmd(2'b01, 0);
    wait_all_idle();

    // ensure_same over 20 cycles: stable, then with a one-cycle glitch.
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      cur = cyc;
      v = N'($urandom_range(0, (1 << N) - 1));
      for (int c = cur + 1; c <= cur + 40; c++) plan[c] = v;
      if (g == 1) plan[cur + 12] = ~v;
      repeat (3) @(negedge clk);
      mon_cmd(2'b10, 20);
      wait_all_idle();
    end

    // Zero-length setter and monitor commands on the same edge.
    fork
      set_cmd(2'b00, '0, 0);
      mon_cmd(2'b11, 0);
    join
    wait_all_idle();

    // Concurrent random traffic.
    fork
      for (int i = 0; i < 40; i++)
        set_cmd(2'($urandom_range(0, 3)), N'($urandom_range(0, (1 << N) - 1)),
                ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12));
      for (int i = 0; i < 40; i++)
        mon_cmd(2'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 25));
    join
    wait_all_idle();

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
